// File: rtl/tabla_pkg.sv
// Shared constants for the tabla loader blocks: stream tag width, loader
// FSM state encoding and a destination-match helper.
package tabla_pkg;

  // Width of the destination PE tag carried with every stream word.
  localparam int unsigned DEST_W = 6;

  // Loader FSM state encoding.
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_LOAD = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // True when a stream word is addressed to the given PE.
  function automatic logic dest_match(input logic [DEST_W-1:0] dest,
                                      input logic [DEST_W-1:0] pe);
    return dest == pe;
  endfunction

endpackage

// File: rtl/buffer_m_ram.sv
// Single-port-write / single-registered-read buffer memory.
// Ports:
//   clk, reset      : clock and synchronous active-high reset (read reg only)
//   we, waddr, wdata: write port
//   raddr           : read address, data appears on rdata one cycle later
//   rdata           : registered read data, old contents on a same-address write
module buffer_m_ram #(
  parameter int unsigned addrLen = 10,
  parameter int unsigned dataLen = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [addrLen-1:0] waddr,
  input  logic [dataLen-1:0] wdata,
  input  logic [addrLen-1:0] raddr,
  output logic [dataLen-1:0] rdata
);

  localparam int unsigned DEPTH = 32'd1 << addrLen;

  // Storage is deliberately left without reset.
  logic [dataLen-1:0] mem_q [DEPTH];
  logic [dataLen-1:0] rdata_q;
  logic [dataLen-1:0] rdata_d;

  // Reading the array before the write lands gives read-before-write.
  always_comb begin
    rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/buffer_m_loader.sv
// Loads a tagged word stream into a local buffer. A session is opened by
// start in IDLE with a word count; matching words (in_dest == peId) are
// stored at consecutive addresses until the count is reached or the sender
// ends its stream early with in_last, which also raises err.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   start, len                   : session request and word count
//   in_valid/in_ready/in_data/
//   in_dest/in_last              : input stream handshake and payload
//   rd_addr, data_out            : buffer read port, one-cycle latency
//   busy, done, err, wr_count    : session status
module buffer_m_loader
  import tabla_pkg::*;
#(
  parameter int unsigned addrLen = 10,
  parameter int unsigned dataLen = 32,
  parameter int unsigned peId    = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addrLen:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [dataLen-1:0] in_data,
  input  logic [DEST_W-1:0]  in_dest,
  input  logic               in_last,
  input  logic [addrLen-1:0] rd_addr,
  output logic [dataLen-1:0] data_out,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [addrLen:0]   wr_count
);

  localparam int unsigned CNT_W = addrLen + 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   wr_count_q, wr_count_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               xfer_c;
  logic               match_c;
  logic               we_c;
  logic               ram_we_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  // Session control: next state, counters and status flags.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_count_d = wr_count_q;
    err_d      = err_q;
    we_c       = 1'b0;
    match_c    = dest_match(in_dest, DEST_W'(peId));
    xfer_c     = in_valid & busy_q;
    cnt_inc_c  = wr_count_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d      = len;
          wr_count_d = '0;
          err_d      = 1'b0;
          state_d    = (len == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer_c && match_c) begin
          we_c       = 1'b1;
          wr_count_d = cnt_inc_c;
          // Reaching the count wins over in_last on the same word.
          if (cnt_inc_c == len_q) begin
            state_d = ST_DONE;
          end else if (in_last) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the next state.
    busy_d = (state_d == ST_LOAD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // A reset arriving mid-session must not land a write.
  assign ram_we_c = we_c & ~reset;

  buffer_m_ram #(
    .addrLen (addrLen),
    .dataLen (dataLen)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we_c),
    .waddr (wr_count_q[addrLen-1:0]),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (data_out)
  );

  assign in_ready = busy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_buffer_m_loader.sv
// Scoreboard bench for buffer_m_loader (addrLen=10, dataLen=32, peId=5).
module tb_buffer_m_loader;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned PE    = 5;
  localparam int unsigned DEPTH = 1024;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AW:0]     len;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [5:0]      in_dest;
  logic            in_last;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   data_out;
  logic            busy;
  logic            done;
  logic            err;
  logic [AW:0]     wr_count;

  buffer_m_loader #(.addrLen(AW), .dataLen(DW), .peId(PE)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_last(in_last), .rd_addr(rd_addr),
    .data_out(data_out), .busy(busy), .done(done), .err(err),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  dest;
    logic        last;
  } word_t;

  typedef struct {
    logic err;
    int   cnt;
  } sess_t;

  word_t       words[$];
  sess_t       exp_sess[$];
  logic [31:0] exp_rd[$];
  logic [31:0] model_mem [DEPTH];

  int   total = 0;
  int   bad = 0;
  int   sess_seen = 0;
  int   sess_target = 0;
  int   wa_g = 0;
  int   last_cnt = 0;
  logic rd_issue = 1'b0;
  logic rd_stage = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // A read issued this cycle is due on data_out after the next edge.
  always @(posedge clk) rd_stage <= rd_issue;

  // Monitor: pops expected read data and session results as the DUT shows them.
  always @(negedge clk) begin
    sess_t s;
    if (rd_stage) begin
      if (exp_rd.size() == 0) fail("read_without_expectation");
      else check("data_out", data_out, exp_rd.pop_front());
    end
    if (done) begin
      sess_seen++;
      if (exp_sess.size() == 0) fail("unexpected_done");
      else begin
        s = exp_sess.pop_front();
        check("sess_err", err, s.err);
        check("sess_wr_count", wr_count, s.cnt);
        check("busy_in_done", busy, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rd_issue = 1'b0;
  endtask

  task automatic do_read(input int a);
    rd_addr  = AW'(a);
    rd_issue = 1'b1;
    exp_rd.push_back(model_mem[a]);
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      do_read(a);
      tick();
    end
  endtask

  // Presents one word (optionally after idle gaps) and records it if stored.
  task automatic send_word(input word_t w, input bit toggle, input bit coll);
    if (toggle) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_dest  = 6'($urandom);
        in_data  = $urandom;
        in_last  = 1'($urandom);
        start    = 1'($urandom);
        len      = (AW+1)'($urandom);
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = w.data;
    in_dest  = w.dest;
    in_last  = w.last;
    if (coll) do_read(wa_g);
    @(negedge clk);
    check("in_ready_in_load", in_ready, 1'b1);
    tick();
    if (w.dest == 6'(PE)) begin
      model_mem[wa_g] = w.data;
      wa_g++;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (sess_seen < sess_target && k < 50) begin
      tick();
      k++;
    end
    if (sess_seen < sess_target) begin
      fail("done_timeout");
      sess_target = sess_seen;
      exp_sess.delete();
    end
  endtask

  // Reference: walk the word list by the session rules to find how many words
  // the loader consumes, how many it stores and whether it ends early.
  task automatic run_session(input int len_v, input bit toggle, input int coll_idx);
    int  cnt = 0;
    bit  e = 1'b0;
    int  n = 0;
    sess_t s;
    if (len_v > 0) begin
      for (int i = 0; i < words.size(); i++) begin
        n = i + 1;
        if (words[i].dest == 6'(PE)) begin
          cnt++;
          if (cnt == len_v) break;
          if (words[i].last) begin
            e = 1'b1;
            break;
          end
        end
      end
    end
    s.err = e;
    s.cnt = cnt;
    exp_sess.push_back(s);
    sess_target++;
    wa_g  = 0;
    start = 1'b1;
    len   = (AW+1)'(len_v);
    tick();
    if (len_v == 0) begin
      start = 1'b0;
      @(negedge clk);
      check("len0_done_next_cycle", done, 1'b1);
      check("len0_in_ready", in_ready, 1'b0);
    end
    for (int i = 0; i < n; i++) send_word(words[i], toggle, i == coll_idx);
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
    wait_done();
    repeat (2) tick();
    check("hold_wr_count", wr_count, cnt);
    check("hold_err", err, e);
    check("idle_in_ready", in_ready, 1'b0);
    last_cnt = cnt;
  endtask

  task automatic add_word(input logic [31:0] d, input int dest, input bit last);
    word_t w;
    w.data = d;
    w.dest = 6'(dest);
    w.last = last;
    words.push_back(w);
  endtask

  initial begin
    int n5;
    int n7;
    int lr;
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; in_dest = '0; in_last = 1'b0; rd_addr = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_data_out", data_out, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_err", err, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    tick();

    // Basic load of 0x11..0x14.
    words.delete();
    for (int i = 0; i < 4; i++) add_word(32'h11 + 32'(i), PE, 1'b0);
    run_session(4, 1'b0, -1);
    read_range(0, 3);

    // Collision: address 2 read while 0xAA is written there.
    words.delete();
    add_word(32'hB0, PE, 1'b0);
    add_word(32'hB1, PE, 1'b0);
    add_word(32'hAA, PE, 1'b0);
    add_word(32'hB3, PE, 1'b0);
    run_session(4, 1'b0, 2);
    do_read(2);
    tick();
    read_range(0, 3);

    // Filtering: dest 5 and dest 7 interleaved, valid toggling.
    words.delete();
    n5 = 0; n7 = 0;
    while (n5 < 6 || n7 < 6) begin
      if (n7 >= 6 || (n5 < 6 && $urandom_range(0, 1) == 1)) begin
        add_word($urandom, PE, 1'b0); n5++;
      end else begin
        add_word($urandom, 7, 1'($urandom)); n7++;
      end
    end
    run_session(5, 1'b1, -1);
    read_range(0, 4);

    // Early end on the third matching word; stray in_last on dest 7 ignored.
    words.delete();
    add_word(32'hC1, PE, 1'b0);
    add_word(32'hDEAD, 7, 1'b1);
    add_word(32'hC2, PE, 1'b0);
    add_word(32'hC3, PE, 1'b1);
    for (int i = 0; i < 6; i++) add_word(32'hC4 + 32'(i), PE, 1'b0);
    run_session(8, 1'b1, -1);
    read_range(0, 2);

    // Zero-length session.
    words.delete();
    run_session(0, 1'b0, -1);

    // Reset after two of six words.
    wa_g  = 0;
    start = 1'b1;
    len   = (AW+1)'(6);
    tick();
    start = 1'b0;
    begin
      word_t w;
      for (int i = 0; i < 2; i++) begin
        w.data = 32'hE0 + 32'(i); w.dest = 6'(PE); w.last = 1'b0;
        send_word(w, 1'b0, 1'b0);
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    reset    = 1'b1;
    tick();
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_wr_count", wr_count, 0);
    check("abort_data_out", data_out, 0);
    reset = 1'b0;
    tick();
    read_range(0, 1);
    words.delete();
    for (int i = 0; i < 6; i++) add_word($urandom, PE, 1'b0);
    run_session(6, 1'b1, -1);
    read_range(0, 5);

    // Random sessions.
    repeat (6) begin
      lr = $urandom_range(1, 16);
      words.delete();
      repeat ($urandom_range(2, 20)) begin
        case ($urandom_range(0, 2))
          0: add_word($urandom, PE, $urandom_range(0, 3) == 0);
          1: add_word($urandom, 7, 1'($urandom));
          default: add_word($urandom, $urandom_range(0, 63), 1'($urandom));
        endcase
      end
      for (int i = 0; i < lr; i++) add_word($urandom, PE, 1'b0);
      run_session(lr, 1'b1, -1);
      if (last_cnt > 0) read_range(0, last_cnt - 1);
    end

    // Full-depth session, in_last on the completing word is ignored.
    words.delete();
    for (int i = 0; i < 1024; i++) add_word($urandom, PE, i == 1023);
    run_session(1024, 1'b0, -1);
    read_range(0, 1023);

    repeat (3) tick();
    check("read_queue_drained", exp_rd.size(), 0);
    check("sess_queue_drained", exp_sess.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence stalls.
  initial begin
    #2000000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/buffer_m_loader.md
BUFFER_M_LOADER -- requirements
Module: buffer_m_loader

Interface
REQ-001 SHALL have parameter addrLen, default 10, buffer address width (depth 2^addrLen words).
REQ-002 SHALL have parameter dataLen, default 32, data word width.
REQ-003 SHALL have parameter peId, default 0, destination tag this instance accepts (0..63).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin a load session (sampled in IDLE only).
REQ-007 SHALL have port len  input  addrLen+1  number of words to load, latched on start.
REQ-008 SHALL have port in_valid  input  1  stream word valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port in_data  input  dataLen  stream payload.
REQ-011 SHALL have port in_dest  input  6  destination PE tag of the word.
REQ-012 SHALL have port in_last  input  1  sender marks final word of its stream.
REQ-013 SHALL have port rd_addr  input  addrLen  read address.
REQ-014 SHALL have port data_out  output  dataLen  registered read data.
REQ-015 SHALL have port busy  output  1  high in LOAD.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of session.
REQ-017 SHALL have port err  output  1  sticky: session ended early by in_last.
REQ-018 SHALL have port wr_count  output  addrLen+1  words written in current/last session.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-020 SHALL, in IDLE with start=1: latch len, clear wr_count and err, go LOAD; if len=0, go DONE instead.
REQ-021 SHALL drive in_ready=1 only in LOAD; a transfer occurs when in_valid and in_ready are both 1.
REQ-022 SHALL, on a transfer with in_dest=peId, write in_data to buffer at address wr_count[addrLen-1:0] and increment wr_count.
REQ-023 SHALL, on a transfer with in_dest!=peId, discard the word, leaving buffer and wr_count unchanged.
REQ-024 SHALL go LOAD->DONE in the cycle after the matching transfer that brings wr_count to len.
REQ-025 SHALL, on a matching transfer with in_last=1 that leaves wr_count<len, write the word, set err, and go DONE.
REQ-026 SHALL ignore in_last on non-matching words and on the word completing len (err stays 0).
REQ-027 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-028 SHALL ignore start outside IDLE.
REQ-029 SHALL support len=2^addrLen, writing addresses 0..2^addrLen-1 without wrap.
REQ-030 SHALL produce data_out = buffer[rd_addr] one cycle after rd_addr is presented, in every state.
REQ-031 SHALL return old data when a read and a write target the same address in the same cycle.
REQ-032 SHALL hold wr_count and err stable from DONE until the next accepted start.

Reset
REQ-033 SHALL, on reset=1 at a clock edge, enter IDLE, clear data_out, wr_count, err, done and busy to 0, and drive in_ready=0.
REQ-034 SHALL abort any session when reset is asserted mid-LOAD, without clearing buffer contents already written.
REQ-035 SHALL not initialise buffer contents on reset; contents are undefined until written.

Structure
REQ-036 SHALL place the FSM state encoding and the destination-tag width constant (6) in the shared tabla package.
REQ-037 SHALL contain one sub-module, buffer_m_ram: single write port plus single registered read port, read-before-write.

Verification
REQ-038 SHALL cover basic load: peId=5, len=4, words 0x11..0x14 with dest 5 -> addresses 0..3 read back 0x11..0x14, done pulses once, err=0, wr_count=4.
REQ-039 SHALL cover filtering: interleave dest 5 and dest 7 words with in_valid toggling -> only the dest 5 words are stored in order, and wr_count counts only those.
REQ-040 SHALL cover early end: len=8, in_last on the 3rd matching word -> err=1, wr_count=3, done pulses.
REQ-041 SHALL cover boundaries: len=0 -> done pulses the cycle after start and in_ready never rises; len=1024 (addrLen=10) -> addresses 0..1023 filled, no wrap.
REQ-042 SHALL cover reset mid-load: assert reset after 2 of 6 words -> IDLE, outputs 0, addresses 0..1 still readable, and a new start loads correctly.
REQ-043 SHALL cover read collision: read address 2 while it is being written with 0xAA (old value 0x13) -> data_out=0x13, then 0xAA on the next read.
